// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes, parity helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Parity over the low nbits of data; even mode returns the XOR, odd its inverse.
  // Also used by the receiver to check incoming frames.
  function automatic logic parity_bit(input logic [8:0] data, input int nbits, input int mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return (mode == PARITY_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side word handshake into the UART transmitter.
// Latency: none (wiring only).
// Backpressure: word transfers when tx_valid & tx_ready; master holds tx_data while tx_ready is low.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_hold.sv
// One-entry holding register between the host handshake and the transmit shifter.
// Latency: a pushed word is visible (hold_full) the cycle after the accept.
// Backpressure: push_rdy is low while full; a pop and a push in one cycle keep it full with the new word.
module uart_tx_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic             pop,
  output logic [WIDTH-1:0] hold_dat,
  output logic             hold_full
);

  logic push;

  assign push_rdy = !hold_full;
  assign push     = push_vld && push_rdy;

  // Capture accepted words; a simultaneous pop and push leaves the entry occupied.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_dat  <= '0;
    end else begin
      if (push) hold_dat <= push_dat;
      if (push)     hold_full <= 1'b1;
      else if (pop) hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Serial transmitter: start, 5..9 data bits LSB first, optional parity (UART_TX_PARITY_EN), 1..2 stop bits.
// Latency: start bit goes out on the first uart_tick edge strictly after the accept; one bit per tick.
// Backpressure: tx_ready low while the holding register is occupied; it frees when the shifter loads.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = PARITY_NONE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             uart_tick,
  uart_tx_frame_if.slave   host,
  output logic             busy,
  output logic             frame_done,
  output logic             TxD
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 fd_q, fd_d;
  logic                 load;
  logic [DATA_BITS-1:0] hold_dat;
  logic                 hold_full;

  uart_tx_hold #(.WIDTH(DATA_BITS)) u_hold (
    .clock     (clock),
    .reset     (reset),
    .push_dat  (host.tx_data),
    .push_vld  (host.tx_valid),
    .push_rdy  (host.tx_ready),
    .pop       (load),
    .hold_dat  (hold_dat),
    .hold_full (hold_full)
  );

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = (PARITY != PARITY_NONE);
  logic par_q;

  // Parity of the word is fixed when it moves from the holding register into the shifter.
  always_ff @(posedge clock) begin
    if (reset)     par_q <= 1'b0;
    else if (load) par_q <= parity_bit(9'(hold_dat), DATA_BITS, PARITY);
  end
`endif

  // State and datapath registers; the line idles high out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      fd_q    <= fd_d;
    end
  end

  // Next-state: everything advances only on a baud tick; frame_done is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    fd_d    = 1'b0;
    load    = 1'b0;
    if (uart_tick) begin
      case (state_q)
        ST_IDLE: begin
          txd_d = 1'b1;
          if (hold_full) begin
            load    = 1'b1;
            shift_d = hold_dat;
            txd_d   = 1'b0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          txd_d   = shift_q[0];
          cnt_d   = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (cnt_q == LAST_DATA) begin
            cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            if (PAR_ON) begin
              txd_d   = par_q;
              state_d = ST_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = ST_STOP;
            end
`else
            txd_d   = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            cnt_d   = cnt_q + 4'd1;
          end
        end
        ST_PARITY: begin
          txd_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (cnt_q == LAST_STOP) begin
            fd_d  = 1'b1;
            cnt_d = '0;
            if (hold_full) begin
              // Back-to-back: next start bit follows the last stop bit with no idle period.
              load    = 1'b1;
              shift_d = hold_dat;
              txd_d   = 1'b0;
              state_d = ST_START;
            end else begin
              txd_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          txd_d   = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers, so TxD is glitch-free.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    frame_done = fd_q;
    TxD        = txd_q;
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: per-cycle comparison against a bit-queue line model.
// Latency: model emits one line bit per tick; a word queued before a tick starts its frame on the next tick.
// Backpressure: host holds tx_valid/tx_data until tx_ready is seen high.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam int DB = 7;
  localparam int SB = 2;
  localparam int PM = 2;
  localparam bit PON = 1'b1;
`else
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int PM = 0;
  localparam bit PON = 1'b0;
`endif

  logic clock, reset, uart_tick, busy, frame_done, TxD;
  uart_tx_frame_if #(.DATA_BITS(DB)) bus ();

  uart_tx_frame #(.DATA_BITS(DB), .STOP_BITS(SB), .PARITY(PM)) dut (
    .clock      (clock),
    .reset      (reset),
    .uart_tick  (uart_tick),
    .host       (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .TxD        (TxD)
  );

  int checks = 0;
  int errors = 0;

  // Line model: pending words, bits of the frame in flight, and expected outputs.
  logic [DB-1:0] pend[$];
  bit            q[$];
  bit            active = 1'b0;
  bit            m_txd = 1'b1;
  bit            m_fd = 1'b0;

  bit cap[$];
  bit cap_en = 1'b0;
  int fd_cnt = 0;
  int tick_per = 16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Baud enable: fixed period, or random 1..4 when tick_per is 0; 1 means every cycle.
  initial begin
    int cnt, cur;
    cnt = 0;
    cur = 1;
    uart_tick = 1'b0;
    forever begin
      @(negedge clock);
      cnt++;
      if (cnt >= cur) begin
        uart_tick = 1'b1;
        cnt = 0;
        cur = (tick_per == 0) ? int'($urandom_range(1, 4)) : tick_per;
      end else begin
        uart_tick = 1'b0;
      end
    end
  end

  // Model step on every edge, then compare the DUT just after the edge.
  initial begin
    bit s_tick, s_acc, s_rst, p;
    logic [DB-1:0] s_dat, w;
    forever begin
      @(posedge clock);
      s_tick = uart_tick;
      s_acc  = bus.tx_valid && bus.tx_ready;
      s_rst  = reset;
      s_dat  = bus.tx_data;
      m_fd   = 1'b0;
      if (s_rst) begin
        pend.delete();
        q.delete();
        active = 1'b0;
        m_txd  = 1'b1;
      end else begin
        if (s_tick) begin
          if (active && q.size() == 0) begin
            m_fd   = 1'b1;
            active = 1'b0;
          end
          if (!active && pend.size() > 0) begin
            w = pend.pop_front();
            q.push_back(1'b0);
            for (int i = 0; i < DB; i++) q.push_back(w[i]);
            if (PON && PM != 0) begin
              p = ^w;
              if (PM == 2) p = ~p;
              q.push_back(p);
            end
            for (int i = 0; i < SB; i++) q.push_back(1'b1);
            active = 1'b1;
          end
          m_txd = active ? q.pop_front() : 1'b1;
        end
        if (s_acc) pend.push_back(s_dat);
      end
      #1;
      chk("txd", 32'(TxD), 32'(m_txd));
      chk("busy", 32'(busy), 32'(active));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("tx_ready", 32'(bus.tx_ready), 32'(pend.size() == 0));
      if (cap_en && s_tick && busy) cap.push_back(TxD);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send(input logic [DB-1:0] w);
    int n = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = w;
    while (!bus.tx_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) chk("send_timeout", 32'(n), 32'(0));
    @(negedge clock);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !bus.tx_ready) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20000) chk("idle_timeout", 32'(n), 32'(0));
    repeat (2) @(negedge clock);
  endtask

  task automatic cap_value(output logic [31:0] v);
    v = '0;
    for (int i = 0; i < cap.size() && i < 32; i++) v[i] = cap[i];
  endtask

  initial begin
    logic [31:0] v;
    logic [DB-1:0] w;
    int base, n;
    reset = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_txd", 32'(TxD), 32'd1);
    chk("reset_ready", 32'(bus.tx_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fd", 32'(frame_done), 32'd0);

    // Single frame at 16 clocks per bit.
    tick_per = 16;
    cap.delete();
    fd_cnt = 0;
    cap_en = 1'b1;
`ifdef UART_TX_PARITY_EN
    send(7'h41);
    wait_idle();
    cap_value(v);
    chk("frame41_bits", v, 32'h782);
    chk("frame41_len", 32'(cap.size()), 32'd11);
`else
    send(8'hA5);
    wait_idle();
    cap_value(v);
    chk("frameA5_bits", v, 32'h34A);
    chk("frameA5_len", 32'(cap.size()), 32'd10);
`endif
    chk("single_fd", 32'(fd_cnt), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);

`ifndef UART_TX_PARITY_EN
    // Back-to-back: second word queued during the first frame.
    cap.delete();
    fd_cnt = 0;
    send(8'h00);
    send(8'hFF);
    wait_idle();
    cap_value(v);
    chk("b2b_bits", v, 32'hFFA00);
    chk("b2b_len", 32'(cap.size()), 32'd20);
    chk("b2b_fd", 32'(fd_cnt), 32'd2);
`endif

    // Reset mid-frame with a second word held.
    tick_per = 4;
    cap.delete();
    w = DB'($urandom);
    send(w);
    n = 0;
    while (cap.size() < 5 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk("mid_reach", 32'(cap.size() >= 5), 32'd1);
    w = DB'($urandom);
    send(w);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_txd", 32'(TxD), 32'd1);
    chk("midrst_ready", 32'(bus.tx_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    fd_cnt = 0;
    repeat (80) @(negedge clock);
    chk("midrst_noframe_fd", 32'(fd_cnt), 32'd0);
    chk("midrst_noframe_busy", 32'(busy), 32'd0);
    cap_en = 1'b0;

    // 100 random words, random tick spacing and random host gaps.
    tick_per = 0;
    base = fd_cnt;
    for (int k = 0; k < 100; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      send(DB'($urandom));
    end
    wait_idle();
    chk("rand_frames", 32'(fd_cnt - base), 32'd100);

    // Continuous tick: one bit per clock, host always ready to send.
    tick_per = 1;
    base = fd_cnt;
    for (int k = 0; k < 20; k++) send(DB'($urandom));
    wait_idle();
    chk("cont_frames", 32'(fd_cnt - base), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
